// File: rtl/sb_pipe.sv
// Three-stage, multi-lane evaluator of sb(z) = log2(1 + 2^z) in signed Q.8 fixed point.
// Positive z is folded through sb(z) = z + sb(-z); sb(n), n <= 0, uses a 5-segment shift-add fit.
module sb_pipe #(
  parameter int W     = 11,
  parameter int LANES = 1,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_z,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_sb,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int XW = W + 2;

  typedef logic signed [XW-1:0] xw_t;
  typedef logic signed [W-1:0]  w_t;

  localparam xw_t LIM_S0 = xw_t'(-64);
  localparam xw_t LIM_S1 = xw_t'(-256);
  localparam xw_t LIM_S2 = xw_t'(-512);
  localparam xw_t LIM_S3 = xw_t'(-1024);
  localparam xw_t OFS_S0 = xw_t'(256);
  localparam xw_t OFS_S1 = xw_t'(248);
  localparam xw_t OFS_S2 = xw_t'(208);
  localparam xw_t OFS_S3 = xw_t'(144);
  localparam xw_t MAX_V  = {3'b000, {(W-1){1'b1}}};
  localparam xw_t MIN_V  = {3'b111, {(W-1){1'b0}}};

  function automatic xw_t sx(input logic [W-1:0] v);
    return xw_t'(w_t'(v));
  endfunction

  // n is already folded to n <= 0, so only the negative half-line is fitted.
  function automatic xw_t seg_eval(input xw_t n);
    xw_t s;
    if (n >= LIM_S0)      s = (n >>> 1) + OFS_S0;
    else if (n >= LIM_S1) s = (n >>> 2) + (n >>> 3) + OFS_S1;
    else if (n >= LIM_S2) s = (n >>> 2) + OFS_S2;
    else if (n >= LIM_S3) s = (n >>> 3) + OFS_S3;
    else                  s = '0;
    return s;
  endfunction

  function automatic w_t sat(input xw_t r);
    w_t o;
    if (r > MAX_V)      o = w_t'(MAX_V);
    else if (r < MIN_V) o = w_t'(MIN_V);
    else                o = w_t'(r);
    return o;
  endfunction

  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic load1, load2, load3, accept;

  logic [LANES-1:0][W-1:0] n1_q, n1_d, z1_q, z1_d;
  logic [LANES-1:0]        pos1_q, pos1_d;
  logic [TAG_W-1:0]        tag1_q, tag1_d;

  logic [LANES-1:0][W-1:0] sb2_q, sb2_d, z2_q, z2_d;
  logic [LANES-1:0]        pos2_q, pos2_d;
  logic [TAG_W-1:0]        tag2_q, tag2_d;

  logic [LANES-1:0][W-1:0] r3_q, r3_d;
  logic [TAG_W-1:0]        tag3_q, tag3_d;

  // Each stage loads when empty or when its successor drains this cycle.
  always_comb begin
    load3 = !v3_q || out_ready;
    load2 = !v2_q || load3;
    load1 = !v1_q || load2;
  end

  assign in_ready = !rst && load1;
  assign accept   = in_valid && in_ready;

  always_comb begin
    v1_d   = v1_q;
    n1_d   = n1_q;
    z1_d   = z1_q;
    pos1_d = pos1_q;
    tag1_d = tag1_q;
    if (load1) begin
      v1_d = accept;
      if (accept) begin
        tag1_d = in_tag;
        for (int k = 0; k < LANES; k++) begin
          z1_d[k]   = in_z[k*W +: W];
          pos1_d[k] = w_t'(in_z[k*W +: W]) > w_t'(0);
          n1_d[k]   = pos1_d[k] ? -in_z[k*W +: W] : in_z[k*W +: W];
        end
      end
    end
  end

  always_comb begin
    v2_d   = v2_q;
    sb2_d  = sb2_q;
    z2_d   = z2_q;
    pos2_d = pos2_q;
    tag2_d = tag2_q;
    if (load2) begin
      v2_d = v1_q;
      if (v1_q) begin
        tag2_d = tag1_q;
        pos2_d = pos1_q;
        z2_d   = z1_q;
        for (int k = 0; k < LANES; k++) begin
          sb2_d[k] = w_t'(seg_eval(sx(n1_q[k])));
        end
      end
    end
  end

  always_comb begin
    v3_d   = v3_q;
    r3_d   = r3_q;
    tag3_d = tag3_q;
    if (load3) begin
      v3_d = v2_q;
      if (v2_q) begin
        tag3_d = tag2_q;
        for (int k = 0; k < LANES; k++) begin
          r3_d[k] = sat(pos2_q[k] ? sx(z2_q[k]) + sx(sb2_q[k]) : sx(sb2_q[k]));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      n1_q   <= '0;
      z1_q   <= '0;
      pos1_q <= '0;
      tag1_q <= '0;
      sb2_q  <= '0;
      z2_q   <= '0;
      pos2_q <= '0;
      tag2_q <= '0;
      r3_q   <= '0;
      tag3_q <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      n1_q   <= n1_d;
      z1_q   <= z1_d;
      pos1_q <= pos1_d;
      tag1_q <= tag1_d;
      sb2_q  <= sb2_d;
      z2_q   <= z2_d;
      pos2_q <= pos2_d;
      tag2_q <= tag2_d;
      r3_q   <= r3_d;
      tag3_q <= tag3_d;
    end
  end

  assign out_valid = v3_q;
  assign out_sb    = r3_q;
  assign out_tag   = tag3_q;

  assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_sb) && $stable(out_tag)));

endmodule

// File: doc/sb_pipe.md
# sb_pipe

Pipelined, multi-lane, handshaked evaluator of the LNS Gaussian-log addition term sb(z) = log2(1 + 2^z), in signed fixed point with 8 fraction bits.
- Accepts z of either sign, folding z > 0 through the identity sb(z) = z + sb(−z).
- Approximates sb with a 5-segment shift-add table and saturates the result.
- Sits between the LNS operand-difference stage and the final exponent adder of the fmadd datapath.
- Replaces the single-lane combinational evaluator.

## Interface
- W, 11: lane width, signed two's complement, 8 fraction bits; legal W ≥ 11.
- LANES, 1: independent lanes sharing one handshake.
- TAG_W, 4: sideband width carried alongside each beat; legal TAG_W ≥ 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the beat this cycle.
- in_z  in  LANES*W  lane k at bits [k*W +: W], signed.
- in_tag  in  TAG_W  opaque sideband.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- out_sb  out  LANES*W  lane k result, signed, same format as in_z.
- out_tag  out  TAG_W  in_tag of the same beat.

## Operation
- Transfer: in_valid && in_ready on input; out_valid && out_ready on output. Beats emerge in order, never dropped or duplicated.
- Per lane, fold:
  - pos = (z > 0).
  - n = pos ? −z : z, so n ≤ 0.
  - z = −2^(W−1) passes through unnegated.
  - n is always representable.
- Segment select on n; ">>>" is arithmetic shift, i.e. floor.
  - S0: n ≥ −64 → (n>>>1) + 256.
  - S1: −256 ≤ n ≤ −65 → (n>>>2) + (n>>>3) + 248.
  - S2: −512 ≤ n ≤ −257 → (n>>>2) + 208.
  - S3: −1024 ≤ n ≤ −513 → (n>>>3) + 144.
  - S4: n < −1024 → 0. Reachable only when W > 11.
- Final: r = pos ? z + sb(n) : sb(n).
  - Compute in W+2 bits.
  - Saturate to [−2^(W−1), 2^(W−1)−1]; in practice only positive overflow occurs.
- Lanes are fully independent; tag bypasses arithmetic.

## Timing
- Three register stages:
  - P1 registers the fold (n, pos, z, tag).
  - P2 registers the segment result sb(n).
  - P3 registers r (saturated) and tag.
  - out_sb and out_tag are driven directly from P3 registers.
- Each stage has its own valid bit.
- A stage loads when it is empty or its downstream stage consumes this cycle (bubble-collapsing).
  - P3 consumes when out_ready.
  - in_ready = !v1 || P1 advances. Combinational from downstream state; no combinational path from in_valid.
- Latency: accepted at edge t → out_valid high after edge t+3 when out_ready is held high.
- Throughput: 1 beat/cycle sustained.
- Backpressure:
  - With out_ready low, holding stages fill; at most 3 beats are held.
  - in_ready drops only when all three stages are full.
  - out_sb/out_tag stay stable while out_valid && !out_ready.
- Simultaneous accept and emit on a full pipe is legal; occupancy is unchanged.
- Reset:
  - While rst is high: all valid bits clear, out_valid = 0, out_sb = 0, out_tag = 0, in_ready = 0.
  - in_ready = 1 on the first cycle after rst falls.
- Reset asserted mid-stream discards every in-flight beat; no beat in flight at reset ever appears at the output.
- Input data is ignored when in_valid = 0; X on in_z must not propagate to out_valid.

## Test plan
- Reset/basic (W=11, LANES=1): rst 2 cycles, then one beat each of z = 0, −64, −65, −100, −300, −1024.
  - out_sb = 256, 224, 222, 210, 133, 16, in order.
  - Each result appears 3 cycles after acceptance.
  - out_valid = 0 and out_sb = 0 during reset.
- Positive fold and saturation:
  - z = +100 → 310.
  - z = +64 → 64 + 224 = 288.
  - z = +1023 → 1023 + 16 = 1039 → saturated 1023.
  - z = −1024 → 16.
- Backpressure: stream 10 beats z = −10·i (i = 0..9) with out_ready low for cycles 4–9.
  - in_ready falls after 3 beats are held.
  - No beat is lost or reordered.
  - out_sb stays stable while stalled.
  - Tags 0..9 return in order.
- Multi-lane (LANES=4): one beat z = {−1024, −300, 0, +100}.
  - out_sb = {16, 133, 256, 310}.
  - Random per-lane streams match a lane-wise reference model.
- Reset mid-operation: assert rst for 1 cycle with 3 beats in flight and out_ready low.
  - out_valid = 0 the next cycle.
  - None of the flushed tags appear afterwards.
  - A new beat z = 0 afterwards returns 256.
- Wide (W=16): z = −2000 → 0 (S4); z = −32768 → 0; z = +2000 → 2000; full random sweep against the model.
